// File: rtl/div_seq_ctrl.sv
// Sequencing controller between EX and the iterative radix-2 divider: issue, wait, drain on flush, HI/LO writeback.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor bypasses the divider and writes lo=all-ones, hi=dividend.
module div_seq_ctrl #(
   parameter int TIMEOUT = 40,
   parameter int CNT_W   = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_signed,
   input  logic [31:0] req_x,
   input  logic [31:0] req_y,
   output logic        req_ready,
   input  logic        flush,
   output logic        busy,
   output logic        div_start,
   output logic        div_signed,
   output logic [31:0] div_x,
   output logic [31:0] div_y,
   input  logic        div_complete,
   input  logic [31:0] div_s,
   input  logic [31:0] div_r,
   output logic        hilo_we,
   output logic [31:0] hi_wdata,
   output logic [31:0] lo_wdata,
   output logic        err_timeout
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] wd_cnt;
   logic             wr_ok;
   logic             accept;
   logic             wd_hit;
   logic             zero_fast;

   assign req_ready = ((state == S_IDLE) || (state == S_DONE)) && !flush;
   assign accept    = req_valid && req_ready;
   // Fires on the cycle whose increment takes the counter to TIMEOUT.
   assign wd_hit    = (wd_cnt == CNT_W'(TIMEOUT - 1));

`ifdef DIV_ZERO_FAST_EN
   assign zero_fast = (req_y == 32'd0);
`else
   assign zero_fast = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = (state != S_IDLE);
      div_start = 1'b0;
      hilo_we   = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) state_nxt = zero_fast ? S_DONE : S_ISSUE;
         end
         S_ISSUE: begin
            div_start = 1'b1;
            state_nxt = flush ? S_DRAIN : S_WAIT;
         end
         S_WAIT: begin
            if (div_complete) state_nxt = S_DONE;
            else if (wd_hit)  state_nxt = S_IDLE;
            else if (flush)   state_nxt = S_DRAIN;
         end
         // The divider cannot abort, so a cancelled op is drained before the next issue.
         S_DRAIN: begin
            if (div_complete || wd_hit) state_nxt = S_IDLE;
         end
         S_DONE: begin
            hilo_we = wr_ok && !flush;
            if (accept) state_nxt = zero_fast ? S_DONE : S_ISSUE;
            else        state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_x       <= '0;
         div_y       <= '0;
         div_signed  <= 1'b0;
         hi_wdata    <= '0;
         lo_wdata    <= '0;
         wd_cnt      <= '0;
         wr_ok       <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         if (accept) begin
            div_x      <= req_x;
            div_y      <= req_y;
            div_signed <= req_signed;
            if (zero_fast) begin
               lo_wdata <= 32'hFFFF_FFFF;
               hi_wdata <= req_x;
               wr_ok    <= 1'b1;
            end
         end
         if (state == S_ISSUE)
            wd_cnt <= '0;
         else if ((state == S_WAIT) || (state == S_DRAIN))
            wd_cnt <= wd_cnt + 1'b1;
         // A flush coinciding with completion still lands in DONE, but with the write blocked.
         if ((state == S_WAIT) && div_complete) begin
            wr_ok <= !flush;
            if (!flush) begin
               lo_wdata <= div_s;
               hi_wdata <= div_r;
            end
         end
         if (((state == S_WAIT) || (state == S_DRAIN)) && !div_complete && wd_hit)
            err_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Randomized scoreboard bench for div_seq_ctrl with a behavioural divider model.
module tb_div_seq_ctrl;
   localparam int TIMEOUT = 40;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_signed, flush;
   logic [31:0] req_x, req_y;
   logic        req_ready, busy, div_start, div_signed;
   logic [31:0] div_x, div_y;
   logic        div_complete;
   logic [31:0] div_s, div_r;
   logic        hilo_we, err_timeout;
   logic [31:0] hi_wdata, lo_wdata;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_cc = 0;
   logic [63:0] exp_q[$];

   div_seq_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_signed(req_signed),
      .req_x(req_x), .req_y(req_y), .req_ready(req_ready), .flush(flush), .busy(busy),
      .div_start(div_start), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
      .div_complete(div_complete), .div_s(div_s), .div_r(div_r), .hilo_we(hilo_we),
      .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference result {remainder, quotient}; a zero divisor yields all-ones / dividend.
   function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic s);
      logic [31:0] q, r;
      if (y == 32'd0) begin
         q = 32'hFFFF_FFFF; r = x;
      end else if (s) begin
         q = $signed(x) / $signed(y); r = $signed(x) % $signed(y);
      end else begin
         q = x / y; r = x % y;
      end
      return {r, q};
   endfunction

   // Divider model: complete pulse 34 cycles after the start cycle.
   logic        div_hang = 1'b0;
   int          dleft;
   logic [31:0] dx, dy;
   logic        ds;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         dleft <= 0; div_complete <= 1'b0; div_s <= '0; div_r <= '0;
         dx <= '0; dy <= '0; ds <= 1'b0;
      end else begin
         div_complete <= 1'b0;
         if (div_start) begin
            dleft <= 33; dx <= div_x; dy <= div_y; ds <= div_signed;
         end else if (dleft > 0) begin
            dleft <= dleft - 1;
            if (dleft == 1 && !div_hang) begin
               {div_r, div_s} <= ref_div(dx, dy, ds);
               div_complete   <= 1'b1;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // Monitor: every HI/LO write must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && div_complete) last_cc = cyc;
      if (!reset && hilo_we) begin
         if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_unexpected_write hi=%0h lo=%0h", hi_wdata, lo_wdata);
         end else begin
            chk("sb_hilo", {hi_wdata, lo_wdata}, exp_q.pop_front());
         end
      end
   end

   task automatic sync();
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s, output int t);
      int i;
      logic got;
      req_x = x; req_y = y; req_signed = s; req_valid = 1'b1;
      got = 1'b0; i = 0; t = 0;
      while (!got && i < 200) begin
         @(negedge clk);
         if (req_ready) begin
            got = 1'b1; t = cyc;
            exp_q.push_back(ref_div(x, y, s));
         end
         @(posedge clk); #1;
         i++;
      end
      req_valid = 1'b0;
      if (!got) begin
         checks++; failures++;
         $display("FAIL issue_timeout got=not_accepted exp=accepted");
      end
   endtask

   task automatic wait_idle();
      int i = 0;
      @(negedge clk);
      while (busy && i < 200) begin
         @(negedge clk); i++;
      end
      if (busy) begin
         checks++; failures++;
         $display("FAIL wait_idle got=busy exp=idle");
      end
      sync();
   endtask

   initial begin
      int t, t2, bad, n;
      logic [31:0] x, y;
      logic s, fl;
      int c, done_off;

      reset = 1'b1; req_valid = 1'b0; req_signed = 1'b0; flush = 1'b0;
      req_x = '0; req_y = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_outs", {busy, div_start, hilo_we, err_timeout, div_signed}, 5'b0);
      chk("rst_ops", {div_x, div_y}, 64'd0);
      chk("rst_hilo", {hi_wdata, lo_wdata}, 64'd0);
      chk("rst_ready", req_ready, 1);
      @(posedge clk); #1; reset = 1'b0;
      sync();

      // Unsigned latency
      issue(32'd100, 32'd7, 1'b0, t);
      @(negedge clk);
      chk("start_t1", div_start, 1);
      repeat (35) @(posedge clk);
      @(negedge clk);
      chk("we_t36", hilo_we, 1);
      chk("we_t36_data", {hi_wdata, lo_wdata}, {32'd2, 32'd14});
      @(negedge clk);
      chk("busy_t37", busy, 0);
      sync();

      // Signed
      issue(32'hFFFF_FFF9, 32'd2, 1'b1, t);
      wait_idle();
      chk("signed_data", {hi_wdata, lo_wdata}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

      // Back-to-back: second request accepted in DONE
      issue(32'd1000, 32'd10, 1'b0, t);
      issue(32'd9, 32'd3, 1'b0, t2);
      @(negedge clk);
      chk("b2b_start", div_start, 1);
      chk("b2b_gap", cyc - last_cc, 2);
      chk("b2b_accept_cyc", t2 - t, 36);
      wait_idle();
      chk("b2b_data", {hi_wdata, lo_wdata}, {32'd0, 32'd3});

      // Flush at T+10 -> drain, no write
      issue(32'd12345, 32'd67, 1'b0, t);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      void'(exp_q.pop_back());
      @(negedge clk);
      chk("flush_ready_low", req_ready, 0);
      @(posedge clk); #1 flush = 1'b0;
      bad = 0; n = 0;
      @(negedge clk);
      while (!div_complete && n < 100) begin
         if (req_ready) bad++;
         @(negedge clk); n++;
      end
      if (req_ready) bad++;
      chk("drain_complete_seen", div_complete, 1);
      chk("drain_ready_low", bad, 0);
      @(negedge clk);
      chk("drain_after_ready", {req_ready, busy}, 2'b10);
      sync();
      issue(32'd77, 32'd5, 1'b0, t);
      wait_idle();

      // Asynchronous reset mid-op
      issue(32'd500, 32'd3, 1'b0, t);
      repeat (19) @(posedge clk);
      #4 reset = 1'b1;
      exp_q.delete();
      #1;
      chk("amid_outs", {busy, div_start, hilo_we, err_timeout, div_signed}, 5'b0);
      chk("amid_regs", {div_x, div_y}, 64'd0);
      chk("amid_hilo", {hi_wdata, lo_wdata}, 64'd0);
      @(posedge clk); #1 reset = 1'b0;
      sync();
      issue(32'd1, 32'd1, 1'b0, t);
      wait_idle();
      chk("post_rst_data", {hi_wdata, lo_wdata}, {32'd0, 32'd1});

      // Zero divisor
      issue(32'd5, 32'd0, 1'b0, t);
`ifdef DIV_ZERO_FAST_EN
      @(negedge clk);
      chk("zero_fast", {div_start, hilo_we}, 2'b01);
`endif
      wait_idle();
      chk("zero_data", {hi_wdata, lo_wdata}, {32'd5, 32'hFFFF_FFFF});

      // Randomized ops, some flushed at a random point up to the DONE cycle
      for (int k = 0; k < 24; k++) begin
         x = $urandom;
         c = $urandom_range(0, 7);
         if (c == 0)      y = 32'd0;
         else if (c < 4)  y = $urandom_range(1, 20);
         else             y = $urandom;
         s = 1'($urandom_range(0, 1));
         if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) y = 32'd1;
         fl = ($urandom_range(0, 3) == 0);
         issue(x, y, s, t);
         if (fl) begin
            done_off = 36;
`ifdef DIV_ZERO_FAST_EN
            if (y == 32'd0) done_off = 1;
`endif
            c = $urandom_range(1, done_off);
            repeat (c - 1) @(posedge clk);
            #1 flush = 1'b1;
            void'(exp_q.pop_back());
            @(posedge clk); #1 flush = 1'b0;
            wait_idle();
         end else if ($urandom_range(0, 1) == 1) begin
            wait_idle();
         end
      end
      wait_idle();

      // Watchdog: divider never completes
      div_hang = 1'b1;
      issue(32'd50, 32'd5, 1'b0, t);
      void'(exp_q.pop_back());
      repeat (TIMEOUT) @(posedge clk);
      @(negedge clk);
      chk("wd_early", err_timeout, 0);
      @(negedge clk);
      chk("wd_fire", {err_timeout, busy}, 2'b10);
      repeat (3) @(negedge clk);
      chk("wd_sticky", err_timeout, 1);
      div_hang = 1'b0;

      chk("sb_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
